// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer (master) and the memory (slave).
interface pc_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             imem_req_o;
  logic [WIDTH-1:0] imem_addr_o;
  logic             imem_ack_i;

  modport master (output imem_req_o, output imem_addr_o, input imem_ack_i);
  modport slave  (input imem_req_o, input imem_addr_o, output imem_ack_i);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues in-order fetches and applies trap/jump/branch redirects.
// Optional macro PC_SEQ_MISALIGN_TRAP_EN replaces misaligned redirect targets with the trap vector.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             trap_valid_i,
  input  logic             jump_valid_i,
  input  logic             branch_valid_i,
  input  logic [WIDTH-1:0] trap_vector_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic [WIDTH-1:0] branch_target_i,
  pc_sequencer_if.master   imem,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  output logic             misalign_o,
`endif
  output logic             flush_o
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b0}}, 2'b11};
  localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-3){1'b0}}, 3'b100};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             redirect_s;
  logic [WIDTH-1:0] tgt_raw_s;
  logic [WIDTH-1:0] tgt_s;
  logic             pc_valid_s;
  logic             misalign_s;

  // Priority-select the redirect target and sanitise its alignment.
  always_comb begin
    redirect_s = trap_valid_i | jump_valid_i | branch_valid_i;
    if (trap_valid_i) begin
      tgt_raw_s = trap_vector_i;
    end else if (jump_valid_i) begin
      tgt_raw_s = jump_target_i;
    end else begin
      tgt_raw_s = branch_target_i;
    end
    misalign_s = redirect_s & ((tgt_raw_s & ALIGN_MASK) != {WIDTH{1'b0}});
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    if (misalign_s) begin
      tgt_s = trap_vector_i;
    end else begin
      tgt_s = tgt_raw_s;
    end
`else
    tgt_s = tgt_raw_s & ~ALIGN_MASK;
`endif
  end

  // Next-state, next-PC and pending-target computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pc_valid_s = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect_s) begin
          pc_d = tgt_s;
        end else begin
          pc_d = pc_q;
        end
      end
      FETCH: begin
        if (redirect_s) begin
          if (imem.imem_ack_i) begin
            pc_d = tgt_s;
          end else begin
            pend_d  = tgt_s;
            state_d = DRAIN;
          end
        end else if (imem.imem_ack_i) begin
          if (stall_i) begin
            state_d = HOLD;
          end else begin
            pc_valid_s = 1'b1;
            pc_d       = pc_q + PC_STEP;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          pc_d    = tgt_s;
          state_d = FETCH;
        end else if (!stall_i) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        // The address on the bus stays pc_q until the abandoned fetch completes.
        if (imem.imem_ack_i) begin
          state_d = FETCH;
          if (redirect_s) begin
            pc_d = tgt_s;
          end else begin
            pc_d = pend_q;
          end
        end else if (redirect_s) begin
          pend_d = tgt_s;
        end else begin
          pend_d = pend_q;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign imem.imem_req_o  = rst & ((state_q == FETCH) | (state_q == DRAIN));
  assign imem.imem_addr_o = rst ? pc_q : RESET_VECTOR;
  assign pc_o             = !rst ? RESET_VECTOR : ((state_q == DRAIN) ? pend_q : pc_q);
  assign pc_valid_o       = rst & pc_valid_s;
  assign flush_o          = rst & redirect_s;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign misalign_o       = rst & misalign_s;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written multi-cycle sequences.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        trap_valid_i, jump_valid_i, branch_valid_i;
  logic [31:0] trap_vector_i, jump_target_i, branch_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, flush_o;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic        misalign_o;
  localparam logic [31:0] MIS_PC = 32'h0000_0900;
`else
  localparam logic [31:0] MIS_PC = 32'h0000_0100;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer_if #(.WIDTH(32)) imem ();

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .trap_valid_i    (trap_valid_i),
    .jump_valid_i    (jump_valid_i),
    .branch_valid_i  (branch_valid_i),
    .trap_vector_i   (trap_vector_i),
    .jump_target_i   (jump_target_i),
    .branch_target_i (branch_target_i),
    .imem            (imem.master),
    .pc_o            (pc_o),
    .pc_valid_o      (pc_valid_o),
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    .misalign_o      (misalign_o),
`endif
    .flush_o         (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ack, stall, tv, jv, bv;
    logic [31:0] tt, jt, bt;
    logic        req;
    logic [31:0] addr, pc;
    logic        valid, flush;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic a, logic s,
                             logic tv, logic [31:0] tt, logic jv, logic [31:0] jt,
                             logic bv, logic [31:0] bt,
                             logic req, logic [31:0] addr, logic [31:0] pc,
                             logic val, logic fl);
    vec_t x;
    x.rst = r; x.ack = a; x.stall = s;
    x.tv = tv; x.tt = tt; x.jv = jv; x.jt = jt; x.bv = bv; x.bt = bt;
    x.req = req; x.addr = addr; x.pc = pc; x.valid = val; x.flush = fl;
    return x;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(logic r, logic a, logic s, logic tv, logic [31:0] tt,
                       logic jv, logic [31:0] jt, logic bv, logic [31:0] bt);
    rst = r; imem.imem_ack_i = a; stall_i = s;
    trap_valid_i = tv; trap_vector_i = tt;
    jump_valid_i = jv; jump_target_i = jt;
    branch_valid_i = bv; branch_target_i = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // rst ack stall | trap | jump | branch | req addr pc valid flush
    vecs.push_back(v(0,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h0,32'h0,0,0));
    vecs.push_back(v(0,1,0, 1,32'h80,0,32'h0, 0,32'h0,     0,32'h0,32'h0,0,0));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h0,32'h0,0,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h0,32'h0,1,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h4,32'h4,1,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h8,32'h8,1,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'hC,32'hC,1,0));
    // stall on ack at 0x10, three stall cycles, refetch 0x10
    vecs.push_back(v(1,1,1, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h10,32'h10,0,0));
    vecs.push_back(v(1,0,1, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h10,32'h10,0,0));
    vecs.push_back(v(1,0,1, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h10,32'h10,0,0));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h10,32'h10,0,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h10,32'h10,1,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h14,32'h14,1,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h18,32'h18,1,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h1C,32'h1C,1,0));
    // branch to 0x100 while 0x20 outstanding, ack two cycles later
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 1,32'h100,   1,32'h20,32'h20,0,1));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h20,32'h100,0,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h20,32'h100,0,0));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h100,32'h100,0,0));
    // trap + jump with ack: trap wins
    vecs.push_back(v(1,1,0, 1,32'h80,1,32'h40, 0,32'h0,    1,32'h100,32'h100,0,1));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h80,32'h80,0,0));
    // repeated redirects while draining; last one with ack wins
    vecs.push_back(v(1,0,0, 0,32'h0, 1,32'h40, 0,32'h0,    1,32'h80,32'h80,0,1));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 1,32'h200,   1,32'h80,32'h40,0,1));
    vecs.push_back(v(1,1,0, 0,32'h0, 1,32'h300,0,32'h0,    1,32'h80,32'h200,0,1));
    vecs.push_back(v(1,0,1, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h300,32'h300,0,0));
    // redirect overriding stall in HOLD
    vecs.push_back(v(1,1,1, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h300,32'h300,0,0));
    vecs.push_back(v(1,0,1, 0,32'h0, 0,32'h0, 1,32'h500,   0,32'h300,32'h300,0,1));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h500,32'h500,0,0));
    // reset mid-fetch, redirect in BOOT with stray ack
    vecs.push_back(v(0,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h0,32'h0,0,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 1,32'h44, 0,32'h0,    0,32'h0,32'h0,0,1));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h44,32'h44,0,0));
    // misaligned jump target
    vecs.push_back(v(1,1,0, 0,32'h900,1,32'h102,0,32'h0,   1,32'h44,32'h44,0,1));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,MIS_PC,MIS_PC,0,0));
    // reset mid-DRAIN, stray ack in BOOT, then PC wrap
    vecs.push_back(v(1,0,0, 0,32'h0, 1,32'hFFFF_FFFC,0,32'h0, 1,MIS_PC,MIS_PC,0,1));
    vecs.push_back(v(0,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h0,32'h0,0,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     0,32'h0,32'h0,0,0));
    vecs.push_back(v(1,1,0, 0,32'h0, 1,32'hFFFF_FFFC,0,32'h0, 1,32'h0,32'h0,0,1));
    vecs.push_back(v(1,1,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'hFFFF_FFFC,32'hFFFF_FFFC,1,0));
    vecs.push_back(v(1,0,0, 0,32'h0, 0,32'h0, 0,32'h0,     1,32'h0,32'h0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].stall, vecs[i].tv, vecs[i].tt,
            vecs[i].jv, vecs[i].jt, vecs[i].bv, vecs[i].bt);
      #2;
      chk("req",   i, {31'd0, imem.imem_req_o}, {31'd0, vecs[i].req});
      chk("addr",  i, imem.imem_addr_o, vecs[i].addr);
      chk("pc",    i, pc_o, vecs[i].pc);
      chk("valid", i, {31'd0, pc_valid_o}, {31'd0, vecs[i].valid});
      chk("flush", i, {31'd0, flush_o}, {31'd0, vecs[i].flush});
      tick();
    end

    // Long ack latency: request and address must hold steady.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #2;
      chk("hold_req",  100 + k, {31'd0, imem.imem_req_o}, 32'd1);
      chk("hold_addr", 100 + k, imem.imem_addr_o, 32'h0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("late_valid", 104, {31'd0, pc_valid_o}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("late_next", 105, imem.imem_addr_o, 32'h4);

    // Misaligned jump with ack: flush pulse and sanitised target.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h900, 1'b1, 32'h102, 1'b0, 32'h0);
    #2;
    chk("mis_flush", 106, {31'd0, flush_o}, 32'd1);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    chk("misalign", 106, {31'd0, misalign_o}, 32'd1);
`endif
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("mis_pc", 107, pc_o, MIS_PC);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    chk("misalign_clr", 107, {31'd0, misalign_o}, 32'd0);
`endif
    chk("mis_flush_clr", 107, {31'd0, flush_o}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
